// File: rtl/fpga_ilvds_align.sv
// Word-alignment controller for a true-LVDS serial input.
// Hunts for TRAIN with a sliding window, confirms the boundary over LOCK_CNT
// words, then emits framed words until LOSS_CNT consecutive decoder errors.
// Optional build macro: ILVDS_ALIGN_POLINV_EN (also accepts an inverted stream).
module fpga_ilvds_align #(
  parameter int           W        = 10,
  parameter logic [W-1:0] TRAIN    = 10'b0011111010,
  parameter int           LOCK_CNT = 4,
  parameter int           LOSS_CNT = 3
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en_i,
  input  logic         din_i,
  input  logic         err_i,
  output logic [W-1:0] word_o,
  output logic         word_vld_o,
  output logic         locked_o,
  output logic         polinv_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sr;
  logic [W-1:0]  cw;
  logic [BW-1:0] bcnt;
  logic [MW-1:0] mcnt, mcnt_nxt, mcnt_inc;
  logic [EW-1:0] ecnt, ecnt_nxt, ecnt_inc;
  logic          inv, inv_nxt;
  logic          wb;
  logic          hunt_true, hunt_inv;
  logic          leave;
  logic          bcnt_clr;
  logic          vld_nxt;

  assign cw        = sr ^ {W{inv}};
  assign wb        = (bcnt == BW'(W - 1));
  assign mcnt_inc  = mcnt + MW'(1);
  assign ecnt_inc  = ecnt + EW'(1);
  assign hunt_true = (sr == TRAIN);
`ifdef ILVDS_ALIGN_POLINV_EN
  assign hunt_inv  = (sr == ~TRAIN);
`else
  assign hunt_inv  = 1'b0;
`endif
  assign polinv_o  = inv;

  // Next-state logic: boundary checks, error hysteresis and same-edge re-hunt.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    ecnt_nxt  = ecnt;
    inv_nxt   = inv;
    vld_nxt   = 1'b0;
    leave     = 1'b0;
    bcnt_clr  = 1'b0;
    if (!en_i) begin
      state_nxt = HUNT;
      mcnt_nxt  = '0;
      ecnt_nxt  = '0;
      inv_nxt   = 1'b0;
    end else begin
      unique case (state)
        HUNT: leave = 1'b1;
        VERIFY: begin
          if (wb) begin
            if (cw == TRAIN) begin
              mcnt_nxt = mcnt_inc;
              if (mcnt_inc == MW'(LOCK_CNT)) begin
                state_nxt = LOCKED;
                ecnt_nxt  = '0;
              end
            end else begin
              leave = 1'b1;
            end
          end
        end
        LOCKED: begin
          vld_nxt = wb;
          if (word_vld_o) begin
            if (err_i) begin
              ecnt_nxt = ecnt_inc;
              if (ecnt_inc == EW'(LOSS_CNT)) leave = 1'b1;
            end else begin
              ecnt_nxt = '0;
            end
          end
        end
        default: leave = 1'b1;
      endcase
      // Falling back to HUNT still evaluates the window on this same edge.
      if (leave) begin
        state_nxt = HUNT;
        mcnt_nxt  = '0;
        ecnt_nxt  = '0;
        inv_nxt   = 1'b0;
        vld_nxt   = 1'b0;
        if (hunt_true || hunt_inv) begin
          bcnt_clr = 1'b1;
          mcnt_nxt = MW'(1);
          inv_nxt  = !hunt_true;
          if (LOCK_CNT == 1) state_nxt = LOCKED;
          else               state_nxt = VERIFY;
        end
      end
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= HUNT;
      sr         <= '0;
      bcnt       <= '0;
      mcnt       <= '0;
      ecnt       <= '0;
      inv        <= 1'b0;
      word_o     <= '0;
      word_vld_o <= 1'b0;
      locked_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= {sr[W-2:0], din_i};
      bcnt       <= (bcnt_clr || wb) ? '0 : bcnt + BW'(1);
      mcnt       <= mcnt_nxt;
      ecnt       <= ecnt_nxt;
      inv        <= inv_nxt;
      word_vld_o <= vld_nxt;
      locked_o   <= (state_nxt == LOCKED);
      if (vld_nxt) word_o <= cw;
    end
  end

endmodule

// File: tb/tb_fpga_ilvds_align.sv
// Self-checking bench for fpga_ilvds_align (W=10, LOCK_CNT=4, LOSS_CNT=3).
module tb_fpga_ilvds_align;

  localparam int           W        = 10;
  localparam logic [W-1:0] TRAIN    = 10'h0FA;
  localparam int           LOCK_CNT = 4;
  localparam int           LOSS_CNT = 3;

  logic         clk = 1'b0;
  logic         arst_n, en_i, din_i, err_i;
  logic [W-1:0] word_o;
  logic         word_vld_o, locked_o, polinv_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpga_ilvds_align #(.W(W), .TRAIN(TRAIN), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk), .arst_n(arst_n), .en_i(en_i), .din_i(din_i), .err_i(err_i),
    .word_o(word_o), .word_vld_o(word_vld_o), .locked_o(locked_o), .polinv_o(polinv_o)
  );

  // Reference model: bit history, anchor edge of the last hunt match,
  // match/error tallies. Boundaries come from (edge - anchor) mod W.
  bit           hist[$];
  int           m_mode;      // 0 hunting, 1 confirming, 2 locked
  int           m_n, m_anchor, m_matches, m_errs;
  logic         m_inv, m_vld;
  logic [W-1:0] m_word;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    m_mode = 0; m_n = 0; m_anchor = 0; m_matches = 0; m_errs = 0;
    m_inv = 1'b0; m_vld = 1'b0; m_word = '0;
  endtask

  function automatic logic [W-1:0] model_window();
    logic [W-1:0] w = '0;
    foreach (hist[i]) w = {w[W-2:0], hist[i]};
    return w;
  endfunction

  task automatic model_edge(input logic d, input logic e, input logic er);
    logic [W-1:0] win, cwm, nword;
    bit           leave, at_bound, pol_ok;
    int           nmode;
    logic         nvld;
    win      = model_window();
    cwm      = win ^ {W{m_inv}};
    at_bound = ((m_n - m_anchor) % W) == 0;
    nmode = m_mode; nvld = 1'b0; nword = m_word; leave = 0;
`ifdef ILVDS_ALIGN_POLINV_EN
    pol_ok = 1;
`else
    pol_ok = 0;
`endif
    if (!e) begin
      nmode = 0; m_matches = 0; m_errs = 0; m_inv = 1'b0;
    end else begin
      if (m_mode == 0) leave = 1;
      else if (m_mode == 1) begin
        if (at_bound) begin
          if (cwm == TRAIN) begin
            m_matches++;
            if (m_matches == LOCK_CNT) begin nmode = 2; m_errs = 0; end
          end else leave = 1;
        end
      end else begin
        if (at_bound) begin nvld = 1'b1; nword = cwm; end
        if (m_vld) begin
          if (er) begin
            m_errs++;
            if (m_errs == LOSS_CNT) leave = 1;
          end else m_errs = 0;
        end
      end
      if (leave) begin
        nmode = 0; m_matches = 0; m_errs = 0; m_inv = 1'b0; nvld = 1'b0; nword = m_word;
        if (win == TRAIN || (pol_ok && win == ~TRAIN)) begin
          m_anchor  = m_n;
          m_matches = 1;
          m_inv     = (win != TRAIN);
          nmode     = (LOCK_CNT == 1) ? 2 : 1;
        end
      end
    end
    m_mode = nmode; m_vld = nvld; m_word = nword;
    hist.push_back(d);
    void'(hist.pop_front());
    m_n++;
  endtask

  task automatic step(input logic d, input logic e, input logic er);
    @(negedge clk);
    din_i = d; en_i = e; err_i = er;
    @(posedge clk);
    #1;
    model_edge(d, e, er);
  endtask

  task automatic flush();
    for (int i = 0; i < 2 * W; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [W-1:0] w;
    logic         b;
    arst_n = 1'b0; en_i = 1'b1; din_i = 1'b0; err_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      vectors++;
      if ({locked_o, polinv_o, word_vld_o, word_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs got=%b/%b/%b/%h want=0/0/0/000", locked_o, polinv_o, word_vld_o, word_o);
      end
    end
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 31; i++) begin
      w = model_window();
      b = (i == 30) ? 1'b0 : 1'($urandom_range(0, 1));
      if ({w[W-2:0], b} == TRAIN || {w[W-2:0], b} == ~TRAIN) b = ~b;
      step(b, 1'b1, 1'b0);
      vectors++;
      if (locked_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_lock cyc=%0d got=%b want=0", i, locked_o);
      end
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] t, w;
    logic         b;
    t = TRAIN;
    for (int i = 0; i < 3; i++) begin
      w = model_window();
      b = 1'($urandom_range(0, 1));
      if ({w[W-2:0], b} == TRAIN || {w[W-2:0], b} == ~TRAIN) b = ~b;
      step(b, 1'b1, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < W; j++) begin
        step(t[W-1-j], 1'b1, 1'b0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL lock_model k=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", k, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
        if (k == 3 && j == W - 1) begin
          vectors++;
          if (locked_o !== 1'b0) begin miscompares++; $display("FAIL lock_early got=%b want=0", locked_o); end
        end
        if (k == 4 && j == 0) begin
          vectors++;
          if (locked_o !== 1'b1 || word_vld_o !== 1'b0) begin
            miscompares++; $display("FAIL lock_rise got=%b/%b want=1/0", locked_o, word_vld_o);
          end
        end
        if (k == 5 && j == 0) begin
          vectors++;
          if (word_vld_o !== 1'b1 || word_o !== 10'h0FA) begin
            miscompares++; $display("FAIL first_word got=%b/%h want=1/0fa", word_vld_o, word_o);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w, prev;
    prev = TRAIN;
    for (int k = 0; k < 6; k++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      for (int j = 0; j < W; j++) begin
        step(w[W-1-j], 1'b1, 1'b0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL b2b_model k=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", k, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
        if (j == 0) begin
          vectors++;
          if (word_vld_o !== 1'b1 || word_o !== prev) begin
            miscompares++; $display("FAIL strobe_period k=%0d got=%b/%h want=1/%h", k, word_vld_o, word_o, prev);
          end
        end
      end
      prev = w;
    end
  endtask

  task automatic test_loss();
    int           errp[9] = '{1, 1, 0, 1, 1, 0, 1, 1, 1};
    logic [W-1:0] w;
    for (int p = 0; p < 9; p++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      for (int j = 0; j < W; j++) begin
        step(w[W-1-j], 1'b1, errp[p] != 0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL loss_model p=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", p, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
        if (p == 4 && j == W - 1) begin
          vectors++;
          if (locked_o !== 1'b1) begin miscompares++; $display("FAIL loss_hold got=%b want=1", locked_o); end
        end
        if (p == 8 && j == 0) begin
          vectors++;
          if (locked_o !== 1'b1 || word_vld_o !== 1'b1) begin
            miscompares++; $display("FAIL loss_pre got=%b/%b want=1/1", locked_o, word_vld_o);
          end
        end
        if (p == 8 && j == 1) begin
          vectors++;
          if (locked_o !== 1'b0 || word_vld_o !== 1'b0) begin
            miscompares++; $display("FAIL loss_drop got=%b/%b want=0/0", locked_o, word_vld_o);
          end
        end
      end
    end
  endtask

  task automatic test_verify_abort();
    logic [W-1:0] seq[8];
    logic [W-1:0] w;
    seq = '{TRAIN, TRAIN, 10'h3FF, TRAIN, TRAIN, TRAIN, TRAIN, TRAIN};
    flush();
    for (int k = 0; k < 8; k++) begin
      w = seq[k];
      for (int j = 0; j < W; j++) begin
        step(w[W-1-j], 1'b1, 1'b0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL abort_model k=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", k, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
        if ((k == 3 && j == 0) || (k == 6 && j == W - 1)) begin
          vectors++;
          if (locked_o !== 1'b0) begin miscompares++; $display("FAIL abort_hold k=%0d got=%b want=0", k, locked_o); end
        end
        if (k == 7 && j == 0) begin
          vectors++;
          if (locked_o !== 1'b1) begin miscompares++; $display("FAIL abort_relock got=%b want=1", locked_o); end
        end
      end
    end
  endtask

  task automatic test_polarity();
    logic [W-1:0] nt;
    nt = ~TRAIN;
    flush();
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < W; j++) begin
        step(nt[W-1-j], 1'b1, 1'b0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL pol_model k=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", k, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
`ifdef ILVDS_ALIGN_POLINV_EN
        if (k == 4 && j == 0) begin
          vectors++;
          if (locked_o !== 1'b1 || polinv_o !== 1'b1) begin
            miscompares++; $display("FAIL pol_lock got=%b/%b want=1/1", locked_o, polinv_o);
          end
        end
        if (k == 5 && j == 0) begin
          vectors++;
          if (word_vld_o !== 1'b1 || word_o !== 10'h0FA) begin
            miscompares++; $display("FAIL pol_word got=%b/%h want=1/0fa", word_vld_o, word_o);
          end
        end
`else
        if ((k == 4 && j == 0) || (k == 5 && j == W - 1)) begin
          vectors++;
          if (locked_o !== 1'b0 || polinv_o !== 1'b0) begin
            miscompares++; $display("FAIL pol_nolock k=%0d got=%b/%b want=0/0", k, locked_o, polinv_o);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] t;
    logic         e;
    t = TRAIN;
    flush();
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < W; j++) begin
        e = !(k == 5 && j == 4);
        step(t[W-1-j], e, 1'b0);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL en_model k=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", k, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
        if ((k == 4 && j == 0) || (k == 9 && j == 0)) begin
          vectors++;
          if (locked_o !== 1'b1) begin miscompares++; $display("FAIL en_locked k=%0d got=%b want=1", k, locked_o); end
        end
        if ((k == 5 && j == 4) || (k == 8 && j == W - 1)) begin
          vectors++;
          if (locked_o !== 1'b0 || word_vld_o !== 1'b0) begin
            miscompares++; $display("FAIL en_unlocked k=%0d got=%b/%b want=0/0", k, locked_o, word_vld_o);
          end
        end
        if (k == 10 && j == 0) begin
          vectors++;
          if (word_vld_o !== 1'b1 || word_o !== TRAIN) begin
            miscompares++; $display("FAIL en_word got=%b/%h want=1/%h", word_vld_o, word_o, TRAIN);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] t;
    t = TRAIN;
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    vectors++;
    if ({locked_o, polinv_o, word_vld_o, word_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got=%b/%b/%b/%h want=0/0/0/000", locked_o, polinv_o, word_vld_o, word_o);
    end
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < W; j++) begin
        step(t[W-1-j], 1'b1, 1'b0);
        if (k == 3 && j == W - 1 || k == 4 && j == 0) begin
          vectors++;
          if (locked_o !== (k == 4)) begin
            miscompares++; $display("FAIL cold_relock k=%0d got=%b want=%b", k, locked_o, k == 4);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int           sel;
    logic         e, er;
    for (int p = 0; p < 80; p++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      w = TRAIN;
      else if (sel < 7) w = ~TRAIN;
      else              w = W'($urandom_range(0, (1 << W) - 1));
      for (int j = 0; j < W; j++) begin
        e  = ($urandom_range(0, 149) != 0);
        er = ($urandom_range(0, 99) < 35);
        step(w[W-1-j], e, er);
        vectors++;
        if ({locked_o, polinv_o, word_vld_o, word_o} !== {m_mode == 2, m_inv, m_vld, m_word}) begin
          miscompares++;
          $display("FAIL rand_model p=%0d j=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", p, j,
                   locked_o, polinv_o, word_vld_o, word_o, m_mode == 2, m_inv, m_vld, m_word);
        end
      end
    end
  endtask

  initial begin
    arst_n = 1'b0; en_i = 1'b1; din_i = 1'b0; err_i = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_back_to_back();
    test_loss();
    test_verify_abort();
    test_polarity();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
